// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite initiator: response codes, default
// protection bits and the transaction FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_initiator.sv
// AXI4-Lite master issuing one write (AW/W/B) or read (AR/R) transaction per
// command, returning the outcome on a valid/ready response port.
module axi_lite_initiator
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    state_e              state_q, state_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_write_q, rsp_write_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    // Next-state and next-output decode for the transaction FSM
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_rdata_d = rsp_rdata_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // AW and W complete independently; each VALID falls after its own handshake
            ST_WR_REQ: begin
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end else begin
                    state_d  = ST_WR_REQ;
                end
            end

            ST_WR_RESP: begin
                if (bready_q && M_AXI_BVALID) begin
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = {DATA_W{1'b0}};
                    rsp_write_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    bready_d    = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end

            ST_RD_REQ: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_RESP;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end

            ST_RD_RESP: begin
                if (rready_q && M_AXI_RVALID) begin
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rready_d    = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_RD_RESP;
                end
            end

            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            // Unreachable encodings fall back to a quiet IDLE
            default: begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= 2'b00;
            rsp_rdata_q <= {DATA_W{1'b0}};
            awaddr_q    <= {ADDR_W{1'b0}};
            araddr_q    <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_rdata_q <= rsp_rdata_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = PROT_DEFAULT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = {(DATA_W/8){1'b1}};
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = PROT_DEFAULT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Bench for axi_lite_initiator: behavioural AXI-Lite slave with programmable
// wait states, a word-array reference model and channel protocol monitoring.
module tb_axi_lite_initiator;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_ready, rsp_valid, rsp_write;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;
    logic [DW-1:0] rdata = '0;

    always #5 clk = ~clk;

    axi_lite_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
        .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // slave configuration for the next transaction
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    // slave state and handshake counters
    int            aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    bit            aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    logic [AW-1:0] got_awaddr = '0, got_araddr = '0;
    logic [DW-1:0] got_wdata = '0;
    logic [DW-1:0] smem [4];
    int            aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

    // values seen at the previous falling edge (held through the rising edge)
    logic          p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic          p_bv = 0, p_br = 0, p_rv = 0, p_rr = 0;
    logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
    logic [DW-1:0] p_wdata = '0;

    // reference model: word array indexed by byte address bits [3:2]
    logic [DW-1:0] ref_mem [4];

    // slave behaviour plus protocol monitor, evaluated on the falling edge
    always @(negedge clk) begin
        if (areset) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
            p_bv = 0; p_br = 0; p_rv = 0; p_rr = 0;
        end else begin
            if (p_awv && !p_awr) begin
                check_eq("aw_hold", 32'(awvalid), 32'd1);
                check_eq("awaddr_stable", 32'(awaddr), 32'(p_awaddr));
            end
            if (p_awv && p_awr) check_eq("aw_drop", 32'(awvalid), 32'd0);
            if (p_wv && !p_wr) begin
                check_eq("w_hold", 32'(wvalid), 32'd1);
                check_eq("wdata_stable", wdata, p_wdata);
            end
            if (p_wv && p_wr) check_eq("w_drop", 32'(wvalid), 32'd0);
            if (p_arv && !p_arr) begin
                check_eq("ar_hold", 32'(arvalid), 32'd1);
                check_eq("araddr_stable", 32'(araddr), 32'(p_araddr));
            end
            if (p_arv && p_arr) check_eq("ar_drop", 32'(arvalid), 32'd0);

            if (p_awv && p_awr) begin aw_hs++; aw_got = 1; got_awaddr = p_awaddr; end
            if (p_wv && p_wr)   begin w_hs++;  w_got = 1;  got_wdata = p_wdata;   end
            if (p_bv && p_br)   begin b_hs++;  bvalid = 0; end
            if (p_arv && p_arr) begin ar_hs++; r_pend = 1; r_wait = 0; got_araddr = p_araddr; end
            if (p_rv && p_rr)   begin r_hs++;  rvalid = 0; end

            if (aw_got && w_got) begin
                smem[got_awaddr[3:2]] = got_wdata;
                aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
            end
            if (b_pend) begin
                if (b_wait >= b_dly) begin bvalid = 1; bresp = bresp_cfg; b_pend = 0; end
                else b_wait++;
            end
            if (r_pend) begin
                if (r_wait >= r_dly) begin
                    rvalid = 1; rresp = rresp_cfg; rdata = smem[got_araddr[3:2]] + 32'd1; r_pend = 0;
                end else r_wait++;
            end

            if (awvalid) begin awready = (aw_wait >= aw_dly); if (!awready) aw_wait++; end
            else begin awready = 0; aw_wait = 0; end
            if (wvalid) begin wready = (w_wait >= w_dly); if (!wready) w_wait++; end
            else begin wready = 0; w_wait = 0; end
            if (arvalid) begin arready = (ar_wait >= ar_dly); if (!arready) ar_wait++; end
            else begin arready = 0; ar_wait = 0; end

            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            p_bv = bvalid; p_br = bready; p_rv = rvalid; p_rr = rready;
        end
    end

    task automatic set_slave(input int a, input int w, input int b, input int ar, input int r,
                             input logic [1:0] br, input logic [1:0] rr);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
        bresp_cfg = br; rresp_cfg = rr;
    endtask

    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int stall, input bit chk_lat);
        int n;
        int aw0, w0, b0, ar0, r0;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_resp;
        @(negedge clk);
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        if (wr) begin
            exp_rdata = '0; exp_resp = bresp_cfg; ref_mem[addr[3:2]] = data;
        end else begin
            exp_rdata = ref_mem[addr[3:2]] + 32'd1; exp_resp = rresp_cfg;
        end
        @(posedge clk);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            cmd_valid = 0;
            n++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin
            check_eq("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        if (chk_lat) check_eq("latency", 32'(n), 32'd3);
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1; cmd_write = ~wr;
            check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check_eq("stall_rdata", rsp_rdata, exp_rdata);
            check_eq("stall_resp", 32'(rsp_resp), 32'(exp_resp));
            @(negedge clk);
        end
        check_eq("rsp_write", 32'(rsp_write), 32'(wr));
        check_eq("rsp_rdata", rsp_rdata, exp_rdata);
        check_eq("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
        cmd_valid = 0;
        check_eq("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check_eq("cmd_ready_after", 32'(cmd_ready), 32'd1);
        check_eq("aw_count", 32'(aw_hs - aw0), wr ? 32'd1 : 32'd0);
        check_eq("w_count",  32'(w_hs - w0),   wr ? 32'd1 : 32'd0);
        check_eq("b_count",  32'(b_hs - b0),   wr ? 32'd1 : 32'd0);
        check_eq("ar_count", 32'(ar_hs - ar0), wr ? 32'd0 : 32'd1);
        check_eq("r_count",  32'(r_hs - r0),   wr ? 32'd0 : 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_awvalid"}, 32'(awvalid), 32'd0);
        check_eq({tag, "_wvalid"}, 32'(wvalid), 32'd0);
        check_eq({tag, "_bready"}, 32'(bready), 32'd0);
        check_eq({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        check_eq({tag, "_rready"}, 32'(rready), 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check_eq({tag, "_awaddr"}, 32'(awaddr), 32'd0);
        check_eq({tag, "_wdata"}, wdata, 32'd0);
        check_eq({tag, "_rsp_fields"}, {rsp_rdata[29:0], rsp_resp}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin smem[i] = '0; ref_mem[i] = '0; end
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check_eq("reset_rsp_write", 32'(rsp_write), 32'd0);
        check_eq("awprot", 32'(awprot), 32'd0);
        check_eq("arprot", 32'(arprot), 32'd0);
        check_eq("wstrb", 32'(wstrb), 32'hF);
        areset = 0;

        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
        run_txn(1, 4'h0, 32'h0000_0041, 0, 1);
        run_txn(0, 4'h0, 32'h0, 0, 1);
        check_eq("add_one_rdata", ref_mem[0] + 32'd1, 32'h0000_0042);

        set_slave(0, 5, 0, 0, 0, 2'b00, 2'b00);
        run_txn(1, 4'h4, 32'hCAFE_F00D, 0, 0);

        set_slave(0, 0, 0, 3, 0, 2'b00, 2'b10);
        run_txn(0, 4'h4, 32'h0, 0, 0);

        set_slave(0, 0, 1, 0, 0, 2'b11, 2'b00);
        run_txn(1, 4'h8, 32'h1234_5678, 4, 0);
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
        run_txn(0, 4'h8, 32'h0, 0, 1);

        // reset while AW/W are still waiting for READY
        set_slave(20, 20, 0, 0, 0, 2'b00, 2'b00);
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'hC; cmd_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check_eq("pre_reset_awvalid", 32'(awvalid), 32'd1);
        areset = 1;
        @(negedge clk);
        check_quiet("midreset");
        @(negedge clk);
        areset = 0;
        @(negedge clk);
        check_eq("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int t = 0; t < 40; t++) begin
            bit wr;
            logic [AW-1:0] a;
            int sa, sw, sb, sar, sr;
            wr = 1'($urandom_range(0, 1));
            a = {2'($urandom_range(0, 3)), 2'b00};
            sa = $urandom_range(0, 4); sw = $urandom_range(0, 4); sb = $urandom_range(0, 3);
            sar = $urandom_range(0, 4); sr = $urandom_range(0, 3);
            set_slave(sa, sw, sb, sar, sr, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            run_txn(wr, a, $urandom, $urandom_range(0, 3),
                    (sa == 0 && sw == 0 && sb == 0 && sar == 0 && sr == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
